cordic_vectoring: RTL and testbench

- Iterative vectoring-mode CORDIC; the inverse of the team's rotation-mode sin/cos core.
- Takes a Cartesian vector (x0, y0) and returns its magnitude and its angle atan2(y0, x0) in degrees.
- Uses the same signed Q7.8 operand format and the same start-pulse control style as the rotation core, so the two can be chained (polar <-> Cartesian) in the datapath.

---
 rtl/cordic_vectoring.sv | 179 +++++++++++++++++
 tb/tb_cordic_vectoring.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x0, y0) in Q7.8 -> magnitude (Q7.8) and
// atan2(y0, x0) in degrees (Q8.8), one micro-rotation per clock.
module cordic_vectoring #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ITER  = 12,
    parameter int GUARD = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic signed [WIDTH-1:0] x0_i,
    input  logic signed [WIDTH-1:0] y0_i,
    output logic signed [WIDTH-1:0] mag_o,
    output logic signed [WIDTH:0]   zn_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int IW     = WIDTH + GUARD + 2;
    localparam int SF     = FRAC + GUARD;
    localparam int MS     = 2 * GUARD + FRAC;
    localparam int PW     = IW + SF + 2;
    localparam int CW     = 5;
    localparam int SH_UP  = (SF >= 12) ? SF - 12 : 0;
    localparam int SH_DN  = (SF >= 12) ? 0 : 12 - SF;
    localparam int ZR_SH  = (GUARD > 0) ? GUARD - 1 : 0;

    // Angle table and gain constant are tabulated at 2^12 and rescaled to the datapath.
    localparam longint K_SF = (64'sd2487 <<< SH_UP) >>> SH_DN;
    localparam logic signed [PW-1:0]  K_W       = PW'(K_SF);
    localparam logic signed [PW-1:0]  RND_M     = PW'(64'sd1 <<< (MS - 1));
    localparam logic signed [PW-1:0]  MAG_MAX   = PW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [WIDTH-1:0] MAG_SAT = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [IW-1:0]  RND_Z     = (GUARD > 0) ? IW'(64'sd1 <<< ZR_SH) : '0;
    localparam logic signed [IW-1:0]  Z90       = IW'(64'sd90 <<< SF);
    localparam logic signed [IW-1:0]  Z180      = IW'(64'sd180 <<< FRAC);
    localparam logic signed [WIDTH:0] ZN180     = (WIDTH+1)'(64'sd180 <<< FRAC);

    function automatic logic signed [IW-1:0] atan_lut(input logic [3:0] idx);
        longint a;
        case (idx)
            4'd0:    a = 64'sd184320;
            4'd1:    a = 64'sd108810;
            4'd2:    a = 64'sd57492;
            4'd3:    a = 64'sd29183;
            4'd4:    a = 64'sd14649;
            4'd5:    a = 64'sd7331;
            4'd6:    a = 64'sd3667;
            4'd7:    a = 64'sd1833;
            4'd8:    a = 64'sd917;
            4'd9:    a = 64'sd458;
            4'd10:   a = 64'sd229;
            4'd11:   a = 64'sd115;
            4'd12:   a = 64'sd57;
            4'd13:   a = 64'sd29;
            4'd14:   a = 64'sd14;
            default: a = 64'sd7;
        endcase
        return IW'((a <<< SH_UP) >>> SH_DN);
    endfunction

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_SCALE = 2'd2} state_t;

    state_t                  r_state, w_state_next;
    logic [CW-1:0]           r_cnt;
    logic signed [IW-1:0]    r_x, r_y, r_z;
    logic                    r_zero, r_negx;
    logic signed [WIDTH-1:0] r_mag;
    logic signed [WIDTH:0]   r_zn;
    logic                    r_done;

    logic                    w_load, w_step, w_finish, w_busy, w_last;
    logic signed [IW-1:0]    w_x0e, w_y0e, w_px, w_py, w_pz;
    logic signed [IW-1:0]    w_xs, w_ys, w_a, w_xn, w_yn, w_zn_acc, w_zr;
    logic signed [PW-1:0]    w_xw, w_prod, w_mag_full;
    logic signed [WIDTH-1:0] w_mag;
    logic signed [WIDTH:0]   w_zn;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    assign w_last = (r_cnt == CW'(ITER - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_next = S_ITER;
            S_ITER:  if (w_last)  w_state_next = S_SCALE;
            S_SCALE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load   = (r_state == S_IDLE) && start_i;
        w_step   = (r_state == S_ITER);
        w_finish = (r_state == S_SCALE);
        w_busy   = (r_state != S_IDLE);
    end

    // Quadrant pre-rotation brings the vector into the right half-plane.
    assign w_x0e = {{(IW-WIDTH){x0_i[WIDTH-1]}}, x0_i} <<< GUARD;
    assign w_y0e = {{(IW-WIDTH){y0_i[WIDTH-1]}}, y0_i} <<< GUARD;

    always_comb begin
        w_px = w_x0e;
        w_py = w_y0e;
        w_pz = '0;
        if (x0_i[WIDTH-1]) begin
            if (!y0_i[WIDTH-1]) begin
                w_px = w_y0e;
                w_py = -w_x0e;
                w_pz = Z90;
            end else begin
                w_px = -w_y0e;
                w_py = w_x0e;
                w_pz = -Z90;
            end
        end
    end

    assign w_xs     = r_x >>> r_cnt;
    assign w_ys     = r_y >>> r_cnt;
    assign w_a      = atan_lut(r_cnt[3:0]);
    assign w_xn     = r_y[IW-1] ? (r_x - w_ys) : (r_x + w_ys);
    assign w_yn     = r_y[IW-1] ? (r_y + w_xs) : (r_y - w_xs);
    assign w_zn_acc = r_y[IW-1] ? (r_z - w_a)  : (r_z + w_a);

    assign w_xw       = {{(PW-IW){r_x[IW-1]}}, r_x};
    assign w_prod     = w_xw * K_W;
    assign w_mag_full = (w_prod + RND_M) >>> MS;
    assign w_mag      = (w_mag_full > MAG_MAX) ? MAG_SAT : w_mag_full[WIDTH-1:0];

    // Angles that drift past +/-180 by the residual error are folded onto +180.
    assign w_zr = (r_z + RND_Z) >>> GUARD;
    assign w_zn = ((w_zr > Z180) || (w_zr <= -Z180)) ? ZN180 : w_zr[WIDTH:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_cnt  <= '0;
            r_zero <= 1'b0;
            r_negx <= 1'b0;
            r_mag  <= '0;
            r_zn   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_x    <= w_px;
                r_y    <= w_py;
                r_z    <= w_pz;
                r_cnt  <= '0;
                r_zero <= (x0_i == '0) && (y0_i == '0);
                r_negx <= x0_i[WIDTH-1] && (y0_i == '0);
            end else if (w_step) begin
                r_x   <= w_xn;
                r_y   <= w_yn;
                r_z   <= w_zn_acc;
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            end
            if (w_finish) begin
                r_mag <= r_zero ? '0 : w_mag;
                r_zn  <= r_zero ? '0 : (r_negx ? ZN180 : w_zn);
            end
        end
    end

    assign mag_o  = r_mag;
    assign zn_o   = r_zn;
    assign busy_o = w_busy;
    assign done_o = r_done;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: stimulus pushes expected results,
// a monitor pops and compares on every done_o pulse.
module tb_cordic_vectoring;

    localparam real PI = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [15:0] x0, y0;
    logic signed [15:0] mag;
    logic signed [16:0] zn;
    logic               busy, done;

    always #5 clk = ~clk;

    cordic_vectoring #(.WIDTH(16), .FRAC(8), .ITER(12), .GUARD(4)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .x0_i    (x0),
        .y0_i    (y0),
        .mag_o   (mag),
        .zn_o    (zn),
        .busy_o  (busy),
        .done_o  (done)
    );

    typedef struct {
        int id;
        int mag;
        int zn;
        int mtol;
        int ztol;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rnd(real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    function automatic logic signed [15:0] to_q(real v);
        return 16'(rnd(v * 256.0));
    endfunction

    task automatic check(int id, string what, int act, int exp, int tol);
        int d;
        tests++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            fails++;
            $display("FAIL vec%0d %s: got %0d, want %0d (tol %0d)", id, what, act, exp, tol);
        end
    endtask

    task automatic check_ang(int id, int act, int exp, int tol);
        int d;
        tests++;
        d = act - exp;
        if (d > 46080) d -= 92160;
        else if (d < -46080) d += 92160;
        if (d < 0) d = -d;
        if (d > tol) begin
            fails++;
            $display("FAIL vec%0d zn: got %0d, want %0d (tol %0d)", id, act, exp, tol);
        end
    endtask

    task automatic push_exp(int id, int em, int ez, int mt, int zt);
        exp_t e;
        e = '{id, em, ez, mt, zt, cyc + 1 + 13};
        sb.push_back(e);
    endtask

    task automatic issue(int id, logic signed [15:0] x, logic signed [15:0] y,
                         int em, int ez, int mt, int zt);
        x0    = x;
        y0    = y;
        start = 1'b1;
        push_exp(id, em, ez, mt, zt);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Start pulse with unrelated operands while busy: must be ignored.
    task automatic junk_pulse();
        repeat (3) @(negedge clk);
        x0    = 16'sh7F00;
        y0    = -16'sh7F00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(int id);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL vec%0d timeout: done_o low after %0d cycles, want high", id, n);
        end
    endtask

    task automatic run_vec(int id, logic signed [15:0] x, logic signed [15:0] y,
                           int em, int ez, int mt, int zt);
        issue(id, x, y, em, ez, mt, zt);
        junk_pulse();
        wait_done(id);
    endtask

    // Monitor: every done_o pulse must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected done_o: mag %0d zn %0d, want no result", int'(mag), int'(zn));
                end else begin
                    e = sb.pop_front();
                    check(e.id, "mag", int'(mag), e.mag, e.mtol);
                    check_ang(e.id, int'(zn), e.zn, e.ztol);
                    check(e.id, "latency", cyc, e.cyc, 0);
                    $display("[TB] vec%0d mag=%0d zn=%0d (exp %0d / %0d) cyc=%0d",
                             e.id, int'(mag), int'(zn), e.mag, e.zn, cyc);
                end
            end
        end
    end

    initial begin
        int          nb;
        int          idx;
        real         ang;
        logic signed [15:0] xq, yq;
        int          em, ez;

        rst   = 1'b1;
        start = 1'b0;
        x0    = '0;
        y0    = '0;
        repeat (3) @(negedge clk);
        check(0, "reset mag", int'(mag), 0, 0);
        check(0, "reset zn", int'(zn), 0, 0);
        check(0, "reset busy", int'(busy), 0, 0);
        check(0, "reset done", int'(done), 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // 45 degrees at radius sqrt(2), with busy duration measured.
        x0    = 16'sh0100;
        y0    = 16'sh0100;
        start = 1'b1;
        push_exp(1, 362, 11520, 4, 26);
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        while (busy && nb < 40) begin
            nb++;
            @(negedge clk);
        end
        check(1, "busy cycles", nb, 13, 0);
        check(1, "done at busy fall", int'(done), 1, 0);

        run_vec(2, 16'shFF00, 16'sh0000, 256, 46080, 4, 26);
        run_vec(3, 16'sh0000, 16'shFE00, 512, -23040, 4, 26);
        run_vec(4, 16'sh6400, 16'sh6400, 32767, 11520, 0, 26);
        run_vec(5, 16'sh0000, 16'sh0000, 0, 0, 0, 0);
        run_vec(6, 16'sh0300, 16'shFC00, 1280, -13601, 4, 26);

        // Angle sweep at radius 10, each start issued in the previous done cycle.
        idx = 10;
        for (int a = -175; a <= 180; a += 5) begin
            ang = real'(a) * PI / 180.0;
            xq  = to_q(10.0 * $cos(ang));
            yq  = to_q(10.0 * $sin(ang));
            em  = rnd($sqrt(real'(xq) * real'(xq) + real'(yq) * real'(yq)));
            ez  = rnd($atan2(real'(yq), real'(xq)) * 180.0 / PI * 256.0);
            run_vec(idx, xq, yq, em, ez, 4, 26);
            idx++;
        end

        // Abort mid-computation: no result, outputs cleared.
        x0    = 16'sh0300;
        y0    = 16'sh0100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check(200, "abort mag", int'(mag), 0, 0);
        check(200, "abort zn", int'(zn), 0, 0);
        check(200, "abort busy", int'(busy), 0, 0);
        check(200, "abort done", int'(done), 0, 0);
        repeat (20) @(negedge clk);
        run_vec(201, 16'sh0300, 16'sh0400, 1280, 13601, 4, 26);

        repeat (20) @(negedge clk);
        check(999, "pending results", sb.size(), 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
